// File: rtl/cpu_control.sv
// Multi-cycle CPU control FSM: fetches, decodes and sequences ALU, load/store,
// NOP and HALT instructions, driving datapath strobes and memory handshakes.
module cpu_control #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic             mem_ack,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [5:0]       opcode,
    output logic [4:0]       oppA,
    output logic [4:0]       oppB,
    output logic [WIDTH-1:0] literal,
    output logic             regEn,
    output logic             increment,
    output logic             Branch_En,
    output logic             fetch,
    output logic             DataBus_En,
    output logic             store_en,
    output logic             wrData,
    output logic             wrAdd,
    output logic             pc_rst,
    output logic             Valid,
    output logic             halted
);

    typedef enum logic [3:0] {
        FETCH_ADDR,
        FETCH_MEM,
        DECODE,
        EXECUTE,
        WRITEBACK,
        LD_MEM,
        ST_DATA,
        ST_MEM,
        HALT
    } state_t;

    localparam logic [5:0] OP_HALT = 6'b10_1111;

    // Field extraction assumes a 32-bit instruction word; AWIDTH only documents the address bus.
    if (WIDTH < 32 || AWIDTH < 1) begin : g_bad_params
    end

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    logic [4:0]       irRa;
    logic [4:0]       irRb;
    logic [1:0]       irClass;
    logic [WIDTH-1:0] immSext;

    assign irRa    = ir_q[25:21];
    assign irRb    = ir_q[20:16];
    assign irClass = ir_q[31:30];
    assign immSext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    assign pc_rst  = reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_ADDR;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Strobes are forced low while reset is high so an aborted request never lingers.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        opcode     = ir_q[31:26];
        oppA       = irRa;
        oppB       = irRb;
        literal    = immSext;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        regEn      = 1'b0;
        increment  = 1'b0;
        Branch_En  = 1'b0;
        fetch      = 1'b0;
        DataBus_En = 1'b0;
        store_en   = 1'b0;
        wrData     = 1'b0;
        wrAdd      = 1'b0;
        Valid      = 1'b0;
        halted     = 1'b0;

        if (!reset) begin
            case (state_q)
                FETCH_ADDR: begin
                    fetch   = 1'b1;
                    wrAdd   = 1'b1;
                    state_d = FETCH_MEM;
                end
                FETCH_MEM: begin
                    mem_rd = 1'b1;
                    if (mem_ack) begin
                        ir_d      = instr[31:0];
                        increment = 1'b1;
                        state_d   = DECODE;
                    end
                end
                DECODE: begin
                    if (ir_q[31:26] == OP_HALT) begin
                        state_d = HALT;
                    end else if (irClass == 2'b10) begin
                        Valid   = 1'b1;
                        state_d = FETCH_ADDR;
                    end else begin
                        state_d = EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (irClass == 2'b01) begin
                        oppA    = irRb;
                        wrAdd   = 1'b1;
                        state_d = ir_q[29] ? ST_DATA : LD_MEM;
                    end else if (irClass == 2'b10) begin
                        state_d = FETCH_ADDR;
                    end else begin
                        wrData  = 1'b1;
                        state_d = WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    regEn   = 1'b1;
                    Valid   = 1'b1;
                    state_d = FETCH_ADDR;
                end
                LD_MEM: begin
                    mem_rd   = 1'b1;
                    store_en = 1'b1;
                    if (mem_ack) begin
                        regEn   = 1'b1;
                        Valid   = 1'b1;
                        state_d = FETCH_ADDR;
                    end
                end
                ST_DATA: begin
                    literal = '0;
                    wrData  = 1'b1;
                    state_d = ST_MEM;
                end
                ST_MEM: begin
                    DataBus_En = 1'b1;
                    mem_wr     = 1'b1;
                    if (mem_ack) begin
                        Valid   = 1'b1;
                        state_d = FETCH_ADDR;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = FETCH_ADDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Scoreboard bench for cpu_control: expected per-cycle outputs are queued per
// instruction and compared cycle by cycle against the DUT.
module tb_cpu_control;

    localparam int WIDTH = 32;

    localparam logic [12:0] S_MEMRD  = 13'h1000;
    localparam logic [12:0] S_MEMWR  = 13'h0800;
    localparam logic [12:0] S_REGEN  = 13'h0400;
    localparam logic [12:0] S_INC    = 13'h0200;
    localparam logic [12:0] S_FETCH  = 13'h0080;
    localparam logic [12:0] S_DBUS   = 13'h0040;
    localparam logic [12:0] S_STEN   = 13'h0020;
    localparam logic [12:0] S_WRDATA = 13'h0010;
    localparam logic [12:0] S_WRADD  = 13'h0008;
    localparam logic [12:0] S_PCRST  = 13'h0004;
    localparam logic [12:0] S_VALID  = 13'h0002;
    localparam logic [12:0] S_HALTED = 13'h0001;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] instr;
    logic             mem_ack;
    logic             mem_rd, mem_wr;
    logic [5:0]       opcode;
    logic [4:0]       oppA, oppB;
    logic [WIDTH-1:0] literal;
    logic             regEn, increment, Branch_En, fetch, DataBus_En;
    logic             store_en, wrData, wrAdd, pc_rst, Valid, halted;

    always #5 clk = ~clk;

    cpu_control #(.WIDTH(WIDTH), .AWIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .mem_ack    (mem_ack),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .opcode     (opcode),
        .oppA       (oppA),
        .oppB       (oppB),
        .literal    (literal),
        .regEn      (regEn),
        .increment  (increment),
        .Branch_En  (Branch_En),
        .fetch      (fetch),
        .DataBus_En (DataBus_En),
        .store_en   (store_en),
        .wrData     (wrData),
        .wrAdd      (wrAdd),
        .pc_rst     (pc_rst),
        .Valid      (Valid),
        .halted     (halted)
    );

    logic [12:0] obsStrobes;
    logic [47:0] obsFields;
    assign obsStrobes = {mem_rd, mem_wr, regEn, increment, Branch_En, fetch, DataBus_En,
                         store_en, wrData, wrAdd, pc_rst, Valid, halted};
    assign obsFields  = {opcode, oppA, oppB, literal};

    logic [12:0] expStrobeQ[$];
    logic [47:0] expFieldQ[$];
    string       expTagQ[$];

    int          testCount = 0;
    int          failCount = 0;
    int          fetchDelay, dataDelay, reqCnt;
    bit          inFetchReq, staleAck;
    logic [31:0] prevIr;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic checkOutput(input string tag, input logic [47:0] observed,
                               input logic [47:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushExp(input string tag, input logic [12:0] s, input logic [31:0] ir,
                           input logic [4:0] a, input logic [4:0] b, input logic [31:0] lit);
        expTagQ.push_back(tag);
        expStrobeQ.push_back(s);
        expFieldQ.push_back({ir[31:26], a, b, lit});
    endtask

    task automatic pushDef(input string tag, input logic [12:0] s, input logic [31:0] ir);
        pushExp(tag, s, ir, ir[25:21], ir[20:16], sext16(ir[15:0]));
    endtask

    // Memory model: acks a fetch after fetchDelay wait cycles, data after dataDelay.
    task automatic respond();
        int delay;
        if (mem_rd || mem_wr) begin
            delay = inFetchReq ? fetchDelay : dataDelay;
            if (reqCnt >= delay) begin
                mem_ack    = 1'b1;
                reqCnt     = 0;
                inFetchReq = 1'b0;
            end else begin
                mem_ack = 1'b0;
                reqCnt++;
            end
        end else begin
            mem_ack = staleAck;
            reqCnt  = 0;
            if (fetch) inFetchReq = 1'b1;
        end
    endtask

    task automatic stepCycle(input logic rst);
        string       tag;
        logic [12:0] es;
        logic [47:0] ef;
        @(negedge clk);
        reset = rst;
        #1;
        respond();
        #1;
        tag = expTagQ.pop_front();
        es  = expStrobeQ.pop_front();
        ef  = expFieldQ.pop_front();
        checkOutput({tag, "_strobes"}, {35'd0, obsStrobes}, {35'd0, es});
        checkOutput({tag, "_fields"}, obsFields, ef);
    endtask

    task automatic runQueue();
        while (expTagQ.size() > 0) stepCycle(1'b0);
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            pushDef("reset", S_PCRST, (i == 0) ? prevIr : 32'h0);
            stepCycle(1'b1);
        end
        prevIr = 32'h0;
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input int fd, input int dd);
        instr      = ins;
        fetchDelay = fd;
        dataDelay  = dd;
        pushDef("fa", S_FETCH | S_WRADD, prevIr);
        for (int i = 0; i < fd; i++) pushDef("fm_wait", S_MEMRD, prevIr);
        pushDef("fm_ack", S_MEMRD | S_INC, prevIr);
        if (ins[31:26] == 6'b10_1111) begin
            pushDef("dec_halt", 13'h0, ins);
        end else if (ins[31:30] == 2'b10) begin
            pushDef("dec_nop", S_VALID, ins);
        end else if (ins[31:30] == 2'b01) begin
            pushDef("dec", 13'h0, ins);
            pushExp("ex_mem", S_WRADD, ins, ins[20:16], ins[20:16], sext16(ins[15:0]));
            if (!ins[29]) begin
                for (int i = 0; i < dd; i++) pushDef("ld_wait", S_MEMRD | S_STEN, ins);
                pushDef("ld_ack", S_MEMRD | S_STEN | S_REGEN | S_VALID, ins);
            end else begin
                pushExp("st_data", S_WRDATA, ins, ins[25:21], ins[20:16], 32'h0);
                for (int i = 0; i < dd; i++) pushDef("st_wait", S_DBUS | S_MEMWR, ins);
                pushDef("st_ack", S_DBUS | S_MEMWR | S_VALID, ins);
            end
        end else begin
            pushDef("dec", 13'h0, ins);
            pushDef("ex_alu", S_WRDATA, ins);
            pushDef("wb", S_REGEN | S_VALID, ins);
        end
        runQueue();
        prevIr = ins;
    endtask

    initial begin
        reset      = 1'b1;
        mem_ack    = 1'b0;
        instr      = '0;
        staleAck   = 1'b0;
        fetchDelay = 0;
        dataDelay  = 0;
        reqCnt     = 0;
        inFetchReq = 1'b0;
        prevIr     = 32'h0;
        repeat (2) @(posedge clk);
        doReset(2);

        applyStimulus(32'h0C22_0000, 0, 0);
        applyStimulus(32'h1000_FFFC, 0, 3);
        applyStimulus(32'h18A3_0010, 0, 1);
        applyStimulus(32'hC0E5_8001, 2, 0);
        applyStimulus(32'h8000_0000, 1, 0);

        staleAck = 1'b1;
        applyStimulus(32'hBC00_0000, 0, 0);
        for (int i = 0; i < 20; i++) pushDef("halt", S_HALTED, prevIr);
        runQueue();
        doReset(2);
        staleAck = 1'b0;

        // Abort a fetch that is still waiting on its ack, then resume with acks always high.
        instr      = 32'h0C22_0000;
        fetchDelay = 10;
        pushDef("fa_abort", S_FETCH | S_WRADD, prevIr);
        repeat (2) pushDef("fm_abort", S_MEMRD, prevIr);
        runQueue();
        doReset(1);
        staleAck = 1'b1;
        applyStimulus(32'h0064_0000, 0, 0);
        applyStimulus(32'h18A3_0010, 0, 2);
        staleAck = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
